// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Execution stage feeding the ALU_out bus. Accepts one
//               operation per valid/ready handshake (3-bit opcode plus two
//               W-bit operands). NOP/ADD/AND/XOR complete in one step; MUL is
//               an iterative shift-add over W cycles. The finished value is
//               presented on `result` together with a one-cycle `done` pulse.
//
//               Build option: define ALU_CORE_FAST_MUL_EN to replace the
//               iterative multiplier with a combinational one, so that MUL
//               finishes with the same latency as the other opcodes.
//
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous reset, active low
//               valid   - opcode/operands present
//               ready   - core can accept (transfer on valid && ready)
//               op      - opcode (000 NOP, 001 ADD, 010 AND, 011 XOR,
//                         100 MUL, others treated as NOP)
//               a, b    - operands, ALU_IN_OP_WIDTH bits
//               done    - one-cycle completion pulse
//               result  - registered result, ALU_OUT_RESULT_WIDTH bits
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core #(
    parameter int ALU_IN_OP_WIDTH      = 8,
    parameter int ALU_OUT_RESULT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid,
    output logic                            ready,
    input  logic [2:0]                      op,
    input  logic [ALU_IN_OP_WIDTH-1:0]      a,
    input  logic [ALU_IN_OP_WIDTH-1:0]      b,
    output logic                            done,
    output logic [ALU_OUT_RESULT_WIDTH-1:0] result
);

    localparam int c_W = ALU_IN_OP_WIDTH;
    localparam int c_R = ALU_OUT_RESULT_WIDTH;

    // The result bus must be able to hold a full W x W product.
    generate
        if (c_R != 2 * c_W) begin : g_width_check
            $error("alu_core: ALU_OUT_RESULT_WIDTH must equal 2*ALU_IN_OP_WIDTH");
        end
    endgenerate

    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_MUL = 3'b100;

    localparam logic [1:0] c_S_IDLE = 2'd0;
`ifndef ALU_CORE_FAST_MUL_EN
    localparam logic [1:0] c_S_EXEC = 2'd1;
`endif
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_next_state;
    logic           w_xfer;
    logic [c_W:0]   w_sum;
    logic [c_R-1:0] w_op_result;
    logic [c_R-1:0] r_result;

`ifndef ALU_CORE_FAST_MUL_EN
    localparam int                c_CNT_W    = (c_W > 1) ? $clog2(c_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_W - 1);

    // Multiplicand shifts left and multiplier shifts right each iteration,
    // so iteration i always looks at bit 0 and adds a<<i.
    logic [c_R-1:0]     r_mcand;
    logic [c_W-1:0]     r_mplier;
    logic [c_R-1:0]     r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_R-1:0]     w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    // Outputs are decodes of the state register only; no input reaches them
    // without passing through a flop.
    assign ready  = (r_state == c_S_IDLE);
    assign done   = (r_state == c_S_DONE);
    assign result = r_result;

    assign w_xfer = valid && (r_state == c_S_IDLE);
    assign w_sum  = {1'b0, a} + {1'b0, b};

    // Single-step results, computed straight from the operands presented at
    // the transfer edge.
    always_comb begin
        w_op_result = '0;
        case (op)
            c_OP_NOP: w_op_result = '0;
            c_OP_ADD: w_op_result[c_W:0]   = w_sum;
            c_OP_AND: w_op_result[c_W-1:0] = a & b;
            c_OP_XOR: w_op_result[c_W-1:0] = a ^ b;
`ifdef ALU_CORE_FAST_MUL_EN
            c_OP_MUL: w_op_result = c_R'(a) * c_R'(b);
`endif
            default:  w_op_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_xfer) begin
`ifndef ALU_CORE_FAST_MUL_EN
                    if (op == c_OP_MUL) begin
                        w_next_state = c_S_EXEC;
                    end else begin
                        w_next_state = c_S_DONE;
                    end
`else
                    w_next_state = c_S_DONE;
`endif
                end
            end
`ifndef ALU_CORE_FAST_MUL_EN
            c_S_EXEC: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_next_state = c_S_DONE;
                end
            end
`endif
            c_S_DONE: w_next_state = c_S_IDLE;
            default:  w_next_state = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
`ifndef ALU_CORE_FAST_MUL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_xfer && (op == c_OP_MUL)) begin
            r_mcand  <= c_R'(a);
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == c_S_EXEC) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`endif

    // result only moves on the way into DONE; it holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
        end else if (w_xfer) begin
`ifndef ALU_CORE_FAST_MUL_EN
            if (op != c_OP_MUL) begin
                r_result <= w_op_result;
            end
`else
            r_result <= w_op_result;
`endif
        end
`ifndef ALU_CORE_FAST_MUL_EN
        else if ((r_state == c_S_EXEC) && (r_cnt == c_CNT_LAST)) begin
            r_result <= w_acc_next;
        end
`endif
    end

endmodule
`default_nettype wire
